// File: rtl/capture_ctrl_pkg.sv
// Shared types and constants for the capture controller: opcodes, sequencer
// states, response bytes and the command field layout.
package capture_ctrl_pkg;

  typedef enum logic [2:0] {
    OP_NOP         = 3'b000,
    OP_DUMP        = 3'b001,
    OP_WR_TRIG_CFG = 3'b010,
    OP_WR_DEC      = 3'b011,
    OP_WR_TRIG_POS = 3'b100,
    OP_CLR_ERR     = 3'b101,
    OP_RD_STATUS   = 3'b110,
    OP_RSVD        = 3'b111
  } op_e;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    WAIT  = 2'd2,
    GAP   = 2'd3
  } state_e;

  localparam logic [7:0] RESP_ACK = 8'hA5;
  localparam logic [7:0] RESP_NAK = 8'hEE;

  localparam int CH_W     = 2;
  localparam int OP_MSB   = 15;
  localparam int OP_LSB   = 13;
  localparam int CH_MSB   = 12;
  localparam int CH_LSB   = 11;
  localparam int DATA_MSB = 8;
  localparam int DATA_LSB = 0;

  function automatic op_e cmd_op(input logic [15:0] c);
    return op_e'(c[OP_MSB:OP_LSB]);
  endfunction

endpackage

// File: rtl/dump_queue.sv
// FIFO of pending dump channels; show-ahead read so the head entry is
// available combinationally on the pop cycle.
module dump_queue
  import capture_ctrl_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            push,
  input  logic [CH_W-1:0] push_data,
  input  logic            pop,
  output logic [CH_W-1:0] pop_data,
  output logic            full,
  output logic            empty,
  output logic [2:0]      count
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(DEPTH - 1);

  logic [CH_W-1:0]  r_mem [DEPTH];
  logic [PTR_W-1:0] r_wr_ptr;
  logic [PTR_W-1:0] r_rd_ptr;
  logic [2:0]       r_count;
  logic             w_do_push;
  logic             w_do_pop;

  assign full      = (r_count == 3'(DEPTH));
  assign empty     = (r_count == 3'd0);
  assign count     = r_count;
  assign pop_data  = r_mem[r_rd_ptr];
  assign w_do_push = push && !full;
  assign w_do_pop  = pop && !empty;

  // NOTE: storage is deliberately not reset; the pointers and count define
  // which entries are valid, so a reset only needs to clear those.
  always_ff @(posedge clk) begin
    if (w_do_push) r_mem[r_wr_ptr] <= push_data;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_do_push) r_wr_ptr <= (r_wr_ptr == PTR_LAST) ? '0 : r_wr_ptr + PTR_W'(1);
      if (w_do_pop)  r_rd_ptr <= (r_rd_ptr == PTR_LAST) ? '0 : r_rd_ptr + PTR_W'(1);
      r_count <= r_count + 3'(w_do_push) - 3'(w_do_pop);
    end
  end

endmodule

// File: rtl/capture_ctrl.sv
// Host-command front end for the capture block: configuration registers,
// queued dump requests and a sequencer that issues them one at a time.
module capture_ctrl
  import capture_ctrl_pkg::*;
#(
  parameter int         DUMP_DEPTH   = 4,
  parameter int         TIMEOUT      = 65535,
  parameter int         GAP_CYCLES   = 16,
  parameter logic [8:0] TRIG_POS_RST = 9'd256
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        cmd_valid,
  input  logic [15:0] cmd,
  output logic        cmd_rdy,
  output logic        resp_valid,
  output logic [7:0]  resp,
  output logic        start_dump,
  output logic [1:0]  dump_channel,
  input  logic        dump_finished,
  input  logic        armed,
  output logic [5:0]  trig_cfg,
  output logic [3:0]  decimator,
  output logic [8:0]  trig_pos,
  output logic        busy,
  output logic        timeout_err
);

  localparam int TMR_MAX = (TIMEOUT > GAP_CYCLES) ? TIMEOUT : GAP_CYCLES;
  localparam int TMR_W   = $clog2(TMR_MAX + 1);
  localparam logic [TMR_W-1:0] TO_LAST  = TMR_W'(TIMEOUT - 1);
  localparam logic [TMR_W-1:0] GAP_LAST = TMR_W'(GAP_CYCLES - 1);

  state_e           r_state, w_state_nxt;
  logic [TMR_W-1:0] r_timer, w_timer_nxt;
  logic [1:0]       r_dump_channel;
  logic             r_resp_valid;
  logic [7:0]       r_resp, w_resp;
  logic [5:0]       r_trig_cfg;
  logic [3:0]       r_decimator;
  logic [8:0]       r_trig_pos;
  logic             r_timeout_err;

  op_e        w_op;
  logic [1:0] w_ch;
  logic [8:0] w_data;
  logic       w_accept, w_push, w_pop, w_to_hit, w_busy;
  logic       w_wr_cfg, w_wr_dec, w_wr_pos, w_clr_err;
  logic [1:0] w_q_data;
  logic       w_q_full, w_q_empty;
  logic [2:0] w_q_count;
  logic       w_unused;

  assign w_op     = cmd_op(cmd);
  assign w_ch     = cmd[CH_MSB:CH_LSB];
  assign w_data   = cmd[DATA_MSB:DATA_LSB];
  assign w_unused = ^cmd[10:9];
  assign cmd_rdy  = !r_resp_valid;
  assign w_accept = cmd_valid && cmd_rdy;
  assign w_busy   = (r_state != IDLE) || !w_q_empty;

  assign resp_valid   = r_resp_valid;
  assign resp         = r_resp;
  assign dump_channel = r_dump_channel;
  assign trig_cfg     = r_trig_cfg;
  assign decimator    = r_decimator;
  assign trig_pos     = r_trig_pos;
  assign busy         = w_busy;
  assign timeout_err  = r_timeout_err;

  dump_queue #(.DEPTH(DUMP_DEPTH)) u_queue (
    .clk       (clk),
    .rst       (rst),
    .push      (w_push),
    .push_data (w_ch),
    .pop       (w_pop),
    .pop_data  (w_q_data),
    .full      (w_q_full),
    .empty     (w_q_empty),
    .count     (w_q_count)
  );

  // NOTE: every signal gets a default before the case so no path leaves one
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    w_resp    = RESP_NAK;
    w_push    = 1'b0;
    w_wr_cfg  = 1'b0;
    w_wr_dec  = 1'b0;
    w_wr_pos  = 1'b0;
    w_clr_err = 1'b0;
    case (w_op)
      OP_NOP:     w_resp = RESP_ACK;
      OP_DUMP: begin
        if (!armed && !w_q_full) begin
          w_push = w_accept;
          w_resp = RESP_ACK;
        end
      end
      OP_WR_TRIG_CFG: if (!w_busy) begin w_wr_cfg = w_accept; w_resp = RESP_ACK; end
      OP_WR_DEC:      if (!w_busy) begin w_wr_dec = w_accept; w_resp = RESP_ACK; end
      OP_WR_TRIG_POS: if (!w_busy) begin w_wr_pos = w_accept; w_resp = RESP_ACK; end
      OP_CLR_ERR: begin
        w_clr_err = w_accept;
        w_resp    = RESP_ACK;
      end
      OP_RD_STATUS: w_resp = {w_busy, r_timeout_err, armed, 2'b00, w_q_count};
      default:      w_resp = RESP_NAK;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_resp_valid  <= 1'b0;
      r_resp        <= '0;
      r_trig_cfg    <= '0;
      r_decimator   <= '0;
      r_trig_pos    <= TRIG_POS_RST;
      r_timeout_err <= 1'b0;
    end else begin
      r_resp_valid <= w_accept;
      if (w_accept) r_resp <= w_resp;
      if (w_wr_cfg) r_trig_cfg  <= w_data[5:0];
      if (w_wr_dec) r_decimator <= w_data[3:0];
      if (w_wr_pos) r_trig_pos  <= w_data;
      // A timeout landing on the same cycle as CLR_ERR is kept, not lost.
      if (w_clr_err) r_timeout_err <= 1'b0;
      if (w_to_hit)  r_timeout_err <= 1'b1;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_timer_nxt = r_timer;
    w_pop       = 1'b0;
    w_to_hit    = 1'b0;
    start_dump  = 1'b0;
    case (r_state)
      IDLE: begin
        if (!w_q_empty) begin
          w_pop       = 1'b1;
          w_state_nxt = START;
        end
      end
      START: begin
        start_dump  = 1'b1;
        w_timer_nxt = '0;
        w_state_nxt = WAIT;
      end
      WAIT: begin
        if (dump_finished) begin
          w_timer_nxt = '0;
          w_state_nxt = GAP;
        end else if (r_timer == TO_LAST) begin
          w_to_hit    = 1'b1;
          w_timer_nxt = '0;
          w_state_nxt = GAP;
        end else begin
          w_timer_nxt = r_timer + TMR_W'(1);
        end
      end
      GAP: begin
        if (r_timer == GAP_LAST) w_state_nxt = IDLE;
        else                     w_timer_nxt = r_timer + TMR_W'(1);
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state        <= IDLE;
      r_timer        <= '0;
      r_dump_channel <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_timer <= w_timer_nxt;
      if (w_pop) r_dump_channel <= w_q_data;
    end
  end

endmodule

// File: tb/tb_capture_ctrl.sv
// Scoreboard bench for capture_ctrl: expected responses and dump channels are
// queued when commands are issued and compared as the DUT produces them.
module tb_capture_ctrl;
  import capture_ctrl_pkg::*;

  localparam int GAP = 16;
  localparam int TO  = 32;

  logic        clk = 1'b0;
  logic        rst;
  logic        cmd_valid;
  logic [15:0] cmd;
  logic        cmd_rdy;
  logic        resp_valid;
  logic [7:0]  resp;
  logic        start_dump;
  logic [1:0]  dump_channel;
  logic        dump_finished;
  logic        armed;
  logic [5:0]  trig_cfg;
  logic [3:0]  decimator;
  logic [8:0]  trig_pos;
  logic        busy;
  logic        timeout_err;

  always #5 clk = ~clk;

  capture_ctrl #(
    .DUMP_DEPTH(4), .TIMEOUT(TO), .GAP_CYCLES(GAP), .TRIG_POS_RST(9'd256)
  ) dut (
    .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd(cmd), .cmd_rdy(cmd_rdy),
    .resp_valid(resp_valid), .resp(resp), .start_dump(start_dump),
    .dump_channel(dump_channel), .dump_finished(dump_finished), .armed(armed),
    .trig_cfg(trig_cfg), .decimator(decimator), .trig_pos(trig_pos),
    .busy(busy), .timeout_err(timeout_err)
  );

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int acc_cyc = 0;
  int starts_seen = 0;
  logic [7:0] exp_resp[$];
  logic [1:0] exp_ch[$];
  logic [7:0] mon_r;
  logic [1:0] mon_c;
  logic       prev_start = 1'b0;

  always @(posedge clk) cyc++;

  // Scoreboard monitor, sampling on the falling edge.
  always @(negedge clk) begin
    if (resp_valid) begin
      checks++;
      if (exp_resp.size() == 0) begin
        errors++;
        $display("FAIL resp_unexpected got %h", resp);
      end else begin
        mon_r = exp_resp.pop_front();
        if (resp !== mon_r) begin
          errors++;
          $display("FAIL resp got %h exp %h (cyc %0d)", resp, mon_r, cyc);
        end
      end
    end
    if (start_dump) begin
      starts_seen++;
      checks++;
      if (exp_ch.size() == 0) begin
        errors++;
        $display("FAIL start_unexpected ch %0d (cyc %0d)", dump_channel, cyc);
      end else begin
        mon_c = exp_ch.pop_front();
        if (dump_channel !== mon_c) begin
          errors++;
          $display("FAIL dump_channel got %0d exp %0d", dump_channel, mon_c);
        end
      end
      checks++;
      if (prev_start !== 1'b0) begin
        errors++;
        $display("FAIL start_width got 2+ cycles exp 1");
      end
    end
    prev_start = start_dump;
  end

  // Called at a falling edge; returns at the falling edge after acceptance.
  task automatic send_cmd(input logic [2:0] op, input logic [1:0] ch,
                          input logic [8:0] data, input logic [7:0] exp);
    int w = 0;
    while (cmd_rdy !== 1'b1 && w < 8) begin @(negedge clk); w++; end
    if (cmd_rdy !== 1'b1) begin
      checks++; errors++;
      $display("FAIL cmd_rdy_wait got %b exp 1", cmd_rdy);
    end
    cmd       = {op, ch, 2'b00, data};
    cmd_valid = 1'b1;
    exp_resp.push_back(exp);
    @(posedge clk);
    @(negedge clk);
    cmd_valid = 1'b0;
    acc_cyc   = cyc;
  endtask

  task automatic wait_start(output int c);
    int w = 0;
    while (start_dump !== 1'b1 && w < 120) begin @(negedge clk); w++; end
    if (start_dump !== 1'b1) begin
      checks++; errors++;
      $display("FAIL start_wait got no start_dump exp one");
    end
    c = cyc;
  endtask

  task automatic pulse_finish(output int c);
    c = cyc;
    dump_finished = 1'b1;
    @(negedge clk);
    dump_finished = 1'b0;
  endtask

  task automatic wait_idle();
    int w = 0;
    while (busy !== 1'b0 && w < 200) begin @(negedge clk); w++; end
    checks++;
    if (busy !== 1'b0) begin
      errors++;
      $display("FAIL idle_wait got busy %b exp 0", busy);
    end
  endtask

  task automatic test_reset();
    repeat (2) @(negedge clk);
    checks++;
    if ({trig_pos, trig_cfg, decimator, start_dump, busy, cmd_rdy, resp_valid} !==
        {9'd256, 6'd0, 4'd0, 1'b0, 1'b0, 1'b1, 1'b0}) begin
      errors++;
      $display("FAIL reset_regs got pos=%0d cfg=%h dec=%h sd=%b busy=%b rdy=%b rv=%b",
               trig_pos, trig_cfg, decimator, start_dump, busy, cmd_rdy, resp_valid);
    end
    rst = 1'b0;
    @(negedge clk);
    send_cmd(OP_RD_STATUS, 2'd0, 9'd0, 8'h00);
  endtask

  task automatic test_registers();
    send_cmd(OP_WR_DEC, 2'd0, 9'd5, RESP_ACK);
    checks++;
    if (decimator !== 4'd5) begin
      errors++; $display("FAIL decimator got %0d exp 5", decimator);
    end
    send_cmd(OP_WR_TRIG_POS, 2'd0, 9'd100, RESP_ACK);
    checks++;
    if (trig_pos !== 9'd100) begin
      errors++; $display("FAIL trig_pos got %0d exp 100", trig_pos);
    end
    send_cmd(OP_WR_TRIG_CFG, 2'd0, 9'h015, RESP_ACK);
    checks++;
    if (trig_cfg !== 6'h15) begin
      errors++; $display("FAIL trig_cfg got %h exp 15", trig_cfg);
    end
    send_cmd(OP_NOP, 2'd0, 9'd0, RESP_ACK);
    send_cmd(OP_RSVD, 2'd0, 9'd0, RESP_NAK);
  endtask

  task automatic test_dump();
    int s, f, n;
    exp_ch.push_back(2'd2);
    send_cmd(OP_DUMP, 2'd2, 9'd0, RESP_ACK);
    wait_start(s);
    checks++;
    if (s !== acc_cyc + 1) begin
      errors++; $display("FAIL dump_latency got %0d exp %0d", s - acc_cyc + 1, 2);
    end
    repeat (20) @(negedge clk);
    pulse_finish(f);
    n = 0;
    while (busy === 1'b1 && n < 100) begin @(negedge clk); n++; end
    checks++;
    if (n !== GAP) begin
      errors++; $display("FAIL busy_drop got %0d exp %0d", n + 1, GAP + 1);
    end
  endtask

  task automatic test_back_to_back();
    int s, f;
    logic [1:0] chs [5] = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd1};
    exp_ch.push_back(2'd3);
    send_cmd(OP_DUMP, 2'd3, 9'd0, RESP_ACK);
    wait_start(s);
    for (int i = 0; i < 5; i++) begin
      if (i < 4) exp_ch.push_back(chs[i]);
      send_cmd(OP_DUMP, chs[i], 9'd0, (i < 4) ? RESP_ACK : RESP_NAK);
    end
    send_cmd(OP_RD_STATUS, 2'd0, 9'd0, 8'h84);
    pulse_finish(f);
    for (int k = 0; k < 4; k++) begin
      wait_start(s);
      checks++;
      if (s - f !== GAP + 2) begin
        errors++; $display("FAIL gap_%0d got %0d exp %0d", k, s - f, GAP + 2);
      end
      repeat (3) @(negedge clk);
      pulse_finish(f);
    end
    wait_idle();
  endtask

  task automatic test_busy_nak();
    int s, f;
    exp_ch.push_back(2'd1);
    send_cmd(OP_DUMP, 2'd1, 9'd0, RESP_ACK);
    wait_start(s);
    send_cmd(OP_WR_TRIG_CFG, 2'd0, 9'h02a, RESP_NAK);
    checks++;
    if (trig_cfg !== 6'h15) begin
      errors++; $display("FAIL trig_cfg_busy got %h exp 15", trig_cfg);
    end
    armed = 1'b1;
    send_cmd(OP_DUMP, 2'd2, 9'd0, RESP_NAK);
    send_cmd(OP_RD_STATUS, 2'd0, 9'd0, 8'hA0);
    armed = 1'b0;
    pulse_finish(f);
    wait_idle();
  endtask

  task automatic test_timeout_reset();
    int s, s2, n0;
    exp_ch.push_back(2'd1);
    exp_ch.push_back(2'd2);
    send_cmd(OP_DUMP, 2'd1, 9'd0, RESP_ACK);
    wait_start(s);
    send_cmd(OP_DUMP, 2'd2, 9'd0, RESP_ACK);
    while (cyc < s + TO) @(negedge clk);
    checks++;
    if (timeout_err !== 1'b0) begin
      errors++; $display("FAIL timeout_early got %b exp 0", timeout_err);
    end
    @(negedge clk);
    checks++;
    if (timeout_err !== 1'b1) begin
      errors++; $display("FAIL timeout_set got %b exp 1", timeout_err);
    end
    send_cmd(OP_RD_STATUS, 2'd0, 9'd0, 8'hC1);
    wait_start(s2);
    checks++;
    if (s2 - s !== TO + GAP + 2) begin
      errors++; $display("FAIL next_after_timeout got %0d exp %0d", s2 - s, TO + GAP + 2);
    end
    send_cmd(OP_CLR_ERR, 2'd0, 9'd0, RESP_ACK);
    checks++;
    if (timeout_err !== 1'b0) begin
      errors++; $display("FAIL clr_err got %b exp 0", timeout_err);
    end
    send_cmd(OP_DUMP, 2'd0, 9'd0, RESP_ACK);
    @(negedge clk);
    rst = 1'b1;
    exp_ch.delete();
    #1;
    checks++;
    if ({start_dump, dump_channel, resp_valid, resp, timeout_err, trig_cfg,
         decimator, trig_pos, busy, cmd_rdy} !==
        {1'b0, 2'd0, 1'b0, 8'h00, 1'b0, 6'd0, 4'd0, 9'd256, 1'b0, 1'b1}) begin
      errors++;
      $display("FAIL async_reset got sd=%b ch=%0d rv=%b r=%h err=%b cfg=%h dec=%h pos=%0d busy=%b rdy=%b",
               start_dump, dump_channel, resp_valid, resp, timeout_err, trig_cfg,
               decimator, trig_pos, busy, cmd_rdy);
    end
    repeat (3) @(negedge clk);
    rst = 1'b0;
    n0 = starts_seen;
    repeat (60) @(negedge clk);
    checks++;
    if (starts_seen !== n0) begin
      errors++; $display("FAIL start_after_reset got %0d exp 0", starts_seen - n0);
    end
    send_cmd(OP_RD_STATUS, 2'd0, 9'd0, 8'h00);
  endtask

  initial begin
    rst = 1'b1; cmd_valid = 1'b0; cmd = '0; dump_finished = 1'b0; armed = 1'b0;
    test_reset();
    test_registers();
    test_dump();
    test_back_to_back();
    test_busy_nak();
    test_timeout_reset();
    repeat (2) @(negedge clk);
    checks++;
    if (exp_resp.size() !== 0 || exp_ch.size() !== 0) begin
      errors++;
      $display("FAIL scoreboard_drain got resp=%0d ch=%0d exp 0 0", exp_resp.size(), exp_ch.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog got timeout exp finish");
    $fatal(1, "watchdog");
  end

endmodule
